// File: rtl/softreg_axil_bridge.sv
// Purpose : soft-register request stream -> AXI4-Lite master for an HLS s_axi_control port.
// Latency : request in cycle N drives AW/W or AR valid in cycle N+2; read data returns 1 cycle after R handshake.
// Backpress: none upstream; requests arriving at a full request FIFO are dropped and counted.
// Ports   : sr_req_* in / sr_resp_* out (softreg side); aw/w/b/ar/r (AXI-Lite master side);
//           err_clear in; ovf_sticky, resp_err_sticky, drop_count, busy status out.
module softreg_axil_bridge #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int LOG_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sr_req_valid,
    input  logic                sr_req_is_write,
    input  logic [31:0]         sr_req_addr,
    input  logic [DATA_W-1:0]   sr_req_data,
    output logic                sr_resp_valid,
    output logic [DATA_W-1:0]   sr_resp_data,
    output logic                awvalid,
    input  logic                awready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                wvalid,
    input  logic                wready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    input  logic                bvalid,
    output logic                bready,
    input  logic [1:0]          bresp,
    output logic                arvalid,
    input  logic                arready,
    output logic [ADDR_W-1:0]   araddr,
    input  logic                rvalid,
    output logic                rready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                err_clear,
    output logic                ovf_sticky,
    output logic                resp_err_sticky,
    output logic [15:0]         drop_count,
    output logic                busy
);

    localparam int DEPTH = 1 << LOG_DEPTH;

    typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA} state_t;
    state_t state, state_nxt;

    // ---------------- request FIFO ----------------
    logic                 fifo_is_wr [DEPTH];
    logic [ADDR_W-1:0]    fifo_addr  [DEPTH];
    logic [DATA_W-1:0]    fifo_data  [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr, rd_ptr;
    logic [LOG_DEPTH:0]   fifo_cnt;
    logic                 fifo_full, fifo_empty, push, pop, drop;

    assign fifo_full  = (fifo_cnt == DEPTH[LOG_DEPTH:0]);
    assign fifo_empty = (fifo_cnt == '0);
    // Acceptance looks only at start-of-cycle occupancy, so a same-cycle pop never rescues a request.
    assign push = sr_req_valid && !fifo_full;
    assign drop = sr_req_valid && fifo_full;
    assign pop  = (state == IDLE) && !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_is_wr[wr_ptr] <= sr_req_is_write;
            fifo_addr[wr_ptr]  <= sr_req_addr[ADDR_W-1:0];
            fifo_data[wr_ptr]  <= sr_req_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // ---------------- transaction FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_empty) state_nxt = fifo_is_wr[rd_ptr] ? WR : RD_ADDR;
            // A channel counts as done if already retired or handshaking now.
            WR:      if ((!awvalid || awready) && (!wvalid || wready)) state_nxt = WR_RESP;
            WR_RESP: if (bvalid)  state_nxt = IDLE;
            RD_ADDR: if (arready) state_nxt = RD_DATA;
            RD_DATA: if (rvalid)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bready = (state == WR_RESP);
    assign rready = (state == RD_DATA);
    assign wstrb  = '1;
    assign busy   = (state != IDLE) || !fifo_empty;

    // Registered AXI valids/payloads; payload only loads when leaving IDLE, so it is stable under valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awvalid       <= 1'b0;
            wvalid        <= 1'b0;
            arvalid       <= 1'b0;
            awaddr        <= '0;
            wdata         <= '0;
            araddr        <= '0;
            sr_resp_valid <= 1'b0;
            sr_resp_data  <= '0;
        end else begin
            sr_resp_valid <= 1'b0;
            if (pop) begin
                if (fifo_is_wr[rd_ptr]) begin
                    awvalid <= 1'b1;
                    wvalid  <= 1'b1;
                    awaddr  <= fifo_addr[rd_ptr];
                    wdata   <= fifo_data[rd_ptr];
                end else begin
                    arvalid <= 1'b1;
                    araddr  <= fifo_addr[rd_ptr];
                end
            end
            if (awvalid && awready) awvalid <= 1'b0;
            if (wvalid && wready)   wvalid  <= 1'b0;
            if (arvalid && arready) arvalid <= 1'b0;
            if (rready && rvalid) begin
                sr_resp_valid <= 1'b1;
                sr_resp_data  <= rdata;
            end
        end
    end

    // ---------------- error / overflow status ----------------
    logic err_event;
    assign err_event = (bready && bvalid && (bresp != 2'b00)) ||
                       (rready && rvalid && (rresp != 2'b00));

    // A new event in the same cycle as err_clear wins over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky      <= 1'b0;
            resp_err_sticky <= 1'b0;
            drop_count      <= '0;
        end else begin
            if (drop) begin
                ovf_sticky <= 1'b1;
                if (err_clear)                  drop_count <= 16'd1;
                else if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end else if (err_clear) begin
                ovf_sticky <= 1'b0;
                drop_count <= '0;
            end
            if (err_event)      resp_err_sticky <= 1'b1;
            else if (err_clear) resp_err_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_softreg_axil_bridge.sv
module tb_softreg_axil_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sr_req_valid, sr_req_is_write;
    logic [31:0] sr_req_addr;
    logic [63:0] sr_req_data;
    logic        sr_resp_valid;
    logic [63:0] sr_resp_data;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] awaddr, araddr;
    logic [63:0] wdata, rdata;
    logic [7:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready;
    logic        err_clear, ovf_sticky, resp_err_sticky, busy;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    softreg_axil_bridge dut (
        .clk(clk), .rst_n(rst_n),
        .sr_req_valid(sr_req_valid), .sr_req_is_write(sr_req_is_write),
        .sr_req_addr(sr_req_addr), .sr_req_data(sr_req_data),
        .sr_resp_valid(sr_resp_valid), .sr_resp_data(sr_resp_data),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .err_clear(err_clear), .ovf_sticky(ovf_sticky),
        .resp_err_sticky(resp_err_sticky), .drop_count(drop_count), .busy(busy)
    );

    int checks   = 0;
    int failures = 0;

    // scoreboard: expectations pushed at stimulus time, popped when the DUT shows the event
    logic [31:0] exp_aw[$];
    logic [63:0] exp_w[$];
    logic [31:0] exp_ar[$];
    logic [63:0] exp_rd[$];
    // slave-side read data to return, in order
    logic [63:0] sl_rdata[$];
    logic [1:0]  sl_rresp[$];

    int   r_delay = 0;
    logic b_en    = 1'b1;
    logic m_aw_hs, m_w_hs, m_b_hs, m_ar_hs, m_r_hs, last_r_hs;
    logic aw_got, w_got, ar_pend;
    int   r_cnt;
    int   resp_pulses = 0;
    logic [31:0] e_a;
    logic [63:0] e_d;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one softreg request for one cycle; caller lowers sr_req_valid afterwards.
    task automatic sr_issue(input logic wr, input logic [31:0] a, input logic [63:0] d,
                            input logic accept, input logic [1:0] rr);
        sr_req_valid    = 1'b1;
        sr_req_is_write = wr;
        sr_req_addr     = a;
        sr_req_data     = d;
        if (accept) begin
            if (wr) begin
                exp_aw.push_back(a);
                exp_w.push_back(d);
            end else begin
                exp_ar.push_back(a);
                exp_rd.push_back(d);
                sl_rdata.push_back(d);
                sl_rresp.push_back(rr);
            end
        end
        step();
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (busy) begin
            failures++;
            $display("FAIL %s_idle_timeout: busy=%0b required 0 within 300 cycles", name, busy);
        end
        step();
        step();
    endtask

    // Monitor (negedge sampling) + AXI-Lite slave model (drives B/R at posedge+1).
    task automatic monitor_slave();
        forever begin
            @(negedge clk);
            m_aw_hs = awvalid && awready;
            m_w_hs  = wvalid && wready;
            m_b_hs  = bvalid && bready;
            m_ar_hs = arvalid && arready;
            m_r_hs  = rvalid && rready;
            if (m_aw_hs) begin
                checks++;
                e_a = (exp_aw.size() != 0) ? exp_aw.pop_front() : 32'hDEAD_BEEF;
                if (awaddr !== e_a) begin
                    failures++;
                    $display("FAIL aw_addr: got %h required %h", awaddr, e_a);
                end
            end
            if (m_w_hs) begin
                checks++;
                e_d = (exp_w.size() != 0) ? exp_w.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
                if (wdata !== e_d || wstrb !== 8'hFF) begin
                    failures++;
                    $display("FAIL w_data: got %h/%h required %h/ff", wdata, wstrb, e_d);
                end
            end
            if (m_ar_hs) begin
                checks++;
                e_a = (exp_ar.size() != 0) ? exp_ar.pop_front() : 32'hDEAD_BEEF;
                if (araddr !== e_a) begin
                    failures++;
                    $display("FAIL ar_addr: got %h required %h", araddr, e_a);
                end
            end
            if (sr_resp_valid === 1'b1) begin
                resp_pulses++;
                checks++;
                e_d = (exp_rd.size() != 0) ? exp_rd.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
                if (sr_resp_data !== e_d) begin
                    failures++;
                    $display("FAIL sr_resp_data: got %h required %h", sr_resp_data, e_d);
                end
                checks++;
                if (last_r_hs !== 1'b1) begin
                    failures++;
                    $display("FAIL sr_resp_timing: R handshake previous cycle=%0b required 1", last_r_hs);
                end
            end
            last_r_hs = m_r_hs;

            @(posedge clk);
            #1;
            if (!rst_n) begin
                bvalid = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; bresp = '0;
                aw_got = 1'b0; w_got = 1'b0; ar_pend = 1'b0;
            end else begin
                if (m_aw_hs) aw_got = 1'b1;
                if (m_w_hs)  w_got  = 1'b1;
                if (m_b_hs)  bvalid = 1'b0;
                if (aw_got && w_got && b_en && !bvalid) begin
                    bvalid = 1'b1;
                    bresp  = 2'b00;
                    aw_got = 1'b0;
                    w_got  = 1'b0;
                end
                if (m_r_hs) rvalid = 1'b0;
                if (m_ar_hs) begin
                    ar_pend = 1'b1;
                    r_cnt   = r_delay;
                end
                if (ar_pend) begin
                    if (r_cnt == 0) begin
                        rvalid  = 1'b1;
                        rdata   = (sl_rdata.size() != 0) ? sl_rdata.pop_front() : 64'h0;
                        rresp   = (sl_rresp.size() != 0) ? sl_rresp.pop_front() : 2'b00;
                        ar_pend = 1'b0;
                    end else begin
                        r_cnt--;
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sr_req_valid = 0; sr_req_is_write = 0; sr_req_addr = '0; sr_req_data = '0;
        awready = 0; wready = 0; arready = 0; err_clear = 0;
        bvalid = 0; bresp = '0; rvalid = 0; rdata = '0; rresp = '0;
        aw_got = 0; w_got = 0; ar_pend = 0; r_cnt = 0; last_r_hs = 0;
        #2;
        checks++;
        if ({awvalid, wvalid, arvalid, bready, rready, sr_resp_valid, busy,
             ovf_sticky, resp_err_sticky} !== 9'b0 || drop_count !== 16'd0 || sr_resp_data !== 64'd0) begin
            failures++;
            $display("FAIL reset_state: ctl=%b drop=%0d data=%h required all zero",
                     {awvalid, wvalid, arvalid, bready, rready, sr_resp_valid, busy,
                      ovf_sticky, resp_err_sticky}, drop_count, sr_resp_data);
        end
        step(); step();
        rst_n = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || awvalid !== 1'b0 || arvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: busy=%b awvalid=%b arvalid=%b required 0", busy, awvalid, arvalid);
        end
    endtask

    task automatic test_write();
        awready = 1; wready = 1;
        sr_issue(1'b1, 32'h10, 64'h1122334455667788, 1'b1, 2'b00);
        sr_req_valid = 0;
        checks++;
        if (awvalid !== 1'b0 || wvalid !== 1'b0) begin
            failures++;
            $display("FAIL wr_latency_n1: awvalid=%b wvalid=%b required 0", awvalid, wvalid);
        end
        step();
        checks++;
        if (awvalid !== 1'b1 || wvalid !== 1'b1 || awaddr !== 32'h10 ||
            wdata !== 64'h1122334455667788 || wstrb !== 8'hFF) begin
            failures++;
            $display("FAIL wr_latency_n2: aw=%b w=%b addr=%h data=%h strb=%h required 1 1 10 1122334455667788 ff",
                     awvalid, wvalid, awaddr, wdata, wstrb);
        end
        step();
        checks++;
        if (bready !== 1'b1 || awvalid !== 1'b0 || wvalid !== 1'b0) begin
            failures++;
            $display("FAIL wr_resp_bready: bready=%b aw=%b w=%b required 1 0 0", bready, awvalid, wvalid);
        end
        wait_idle("write");
    endtask

    task automatic test_w_before_aw();
        awready = 0; wready = 1;
        sr_issue(1'b1, 32'h20, 64'hA5A5_0000_1234_5678, 1'b1, 2'b00);
        sr_req_valid = 0;
        step();
        checks++;
        if (awvalid !== 1'b1 || wvalid !== 1'b1) begin
            failures++;
            $display("FAIL split_start: aw=%b w=%b required 1 1", awvalid, wvalid);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 2) awready = 1;
            checks++;
            if (wvalid !== 1'b0 || awvalid !== 1'b1 || bready !== 1'b0) begin
                failures++;
                $display("FAIL split_wait%0d: w=%b aw=%b bready=%b required 0 1 0", i, wvalid, awvalid, bready);
            end
        end
        step();
        checks++;
        if (awvalid !== 1'b0 || bready !== 1'b1) begin
            failures++;
            $display("FAIL split_done: aw=%b bready=%b required 0 1", awvalid, bready);
        end
        wait_idle("split");
    endtask

    task automatic test_read();
        int p0;
        arready = 1; r_delay = 5;
        p0 = resp_pulses;
        sr_issue(1'b0, 32'h18, 64'hCAFE, 1'b1, 2'b00);
        sr_req_valid = 0;
        wait_idle("read");
        checks++;
        if (resp_pulses - p0 !== 1) begin
            failures++;
            $display("FAIL read_pulses: got %0d required 1", resp_pulses - p0);
        end
    endtask

    // One write is parked in WR first so the FIFO itself sees the burst: 4 fit, 2 drop.
    task automatic test_overflow();
        awready = 0; wready = 1;
        sr_issue(1'b1, 32'h100, 64'h100, 1'b1, 2'b00);
        sr_req_valid = 0;
        step();
        for (int i = 0; i < 6; i++)
            sr_issue(1'b1, 32'h200 + 32'(i * 8), 64'h200 + 64'(i), (i < 4), 2'b00);
        sr_req_valid = 0;
        checks++;
        if (drop_count !== 16'd2 || ovf_sticky !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL overflow: drop=%0d ovf=%b busy=%b required 2 1 1", drop_count, ovf_sticky, busy);
        end
        awready = 1;
        wait_idle("overflow");
    endtask

    task automatic test_interleave();
        awready = 1; wready = 1; arready = 1; r_delay = 1;
        checks++;
        if (resp_err_sticky !== 1'b0) begin
            failures++;
            $display("FAIL err_pre: resp_err=%b required 0", resp_err_sticky);
        end
        sr_issue(1'b1, 32'h0, 64'h0BAD_F00D, 1'b1, 2'b00);
        sr_issue(1'b0, 32'h4, 64'h4444, 1'b1, 2'b00);
        sr_issue(1'b0, 32'h8, 64'h8888, 1'b1, 2'b10);
        sr_req_valid = 0;
        wait_idle("interleave");
        checks++;
        if (resp_err_sticky !== 1'b1 || ovf_sticky !== 1'b1 || drop_count !== 16'd2) begin
            failures++;
            $display("FAIL err_set: resp_err=%b ovf=%b drop=%0d required 1 1 2",
                     resp_err_sticky, ovf_sticky, drop_count);
        end
        err_clear = 1;
        step();
        err_clear = 0;
        checks++;
        if (resp_err_sticky !== 1'b0 || ovf_sticky !== 1'b0 || drop_count !== 16'd0) begin
            failures++;
            $display("FAIL err_clear: resp_err=%b ovf=%b drop=%0d required 0 0 0",
                     resp_err_sticky, ovf_sticky, drop_count);
        end
    endtask

    task automatic test_clear_collision();
        awready = 0; wready = 1;
        sr_issue(1'b1, 32'h300, 64'h300, 1'b1, 2'b00);
        sr_req_valid = 0;
        step();
        for (int i = 0; i < 5; i++)
            sr_issue(1'b1, 32'h400 + 32'(i * 8), 64'h400 + 64'(i), (i < 4), 2'b00);
        err_clear = 1;
        sr_issue(1'b1, 32'h500, 64'h500, 1'b0, 2'b00);
        err_clear = 0;
        sr_req_valid = 0;
        checks++;
        if (drop_count !== 16'd1 || ovf_sticky !== 1'b1) begin
            failures++;
            $display("FAIL clear_collision: drop=%0d ovf=%b required 1 1", drop_count, ovf_sticky);
        end
        awready = 1;
        wait_idle("collision");
    endtask

    task automatic test_reset_mid();
        int n = 0;
        awready = 1; wready = 1; b_en = 0;
        sr_issue(1'b1, 32'h40, 64'h4040, 1'b1, 2'b00);
        sr_req_valid = 0;
        while (bready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (bready !== 1'b1) begin
            failures++;
            $display("FAIL reach_wr_resp: bready=%b required 1", bready);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({awvalid, wvalid, arvalid, bready, rready, sr_resp_valid, busy,
             ovf_sticky, resp_err_sticky} !== 9'b0 || drop_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_mid: ctl=%b drop=%0d required all zero",
                     {awvalid, wvalid, arvalid, bready, rready, sr_resp_valid, busy,
                      ovf_sticky, resp_err_sticky}, drop_count);
        end
        step(); step();
        rst_n = 1'b1;
        b_en  = 1;
        step();
        arready = 1; r_delay = 2;
        sr_issue(1'b0, 32'h50, 64'h5555_AAAA, 1'b1, 2'b00);
        sr_req_valid = 0;
        wait_idle("post_reset_read");
    endtask

    initial begin
        test_reset();
        fork
            monitor_slave();
        join_none
        test_write();
        test_w_before_aw();
        test_read();
        test_overflow();
        test_interleave();
        test_clear_collision();
        test_reset_mid();
        checks++;
        if (exp_aw.size() + exp_w.size() + exp_ar.size() + exp_rd.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: pending aw=%0d w=%0d ar=%0d rd=%0d required 0",
                     exp_aw.size(), exp_w.size(), exp_ar.size(), exp_rd.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
